// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO read-side drain stage.
// Holds the skid-buffer depth, the occupancy type and a saturating increment.
package fifo_stream_pkg;

    localparam int unsigned SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

    // Increment v, clamping at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (v >= max_val) ? max_val : (v + 64'd1);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; entry 0 is always the head.
// Supports a same-cycle push and pop, and a flush that empties it on the next edge.
module fifo_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output occ_t                  occ_o,
    output logic [DATA_WIDTH-1:0] head_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    occ_t                  occ_q;
    occ_t                  occ_d;
    logic                  wr_idx;

    always_comb begin
        mem_d  = mem_q;
        occ_d  = occ_q;
        // Tail slot after any pop this cycle; a push only happens when this is 0 or 1.
        wr_idx = ((occ_q - occ_t'(pop_i)) != '0);
        if (flush_i) begin
            occ_d = '0;
        end else begin
            if (pop_i && (occ_q == occ_t'(SKID_DEPTH))) begin
                mem_d[0] = mem_q[1];
            end
            if (push_i) begin
                mem_d[wr_idx] = push_data_i;
            end
            occ_d = occ_q + occ_t'(push_i) - occ_t'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            occ_q <= occ_d;
        end
    end

    assign occ_o       = occ_q;
    assign head_data_o = mem_q[0];

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream through a skid buffer.
// Also keeps a wrapping beat counter, a saturating stall counter and a sticky underflow flag.
module fifo_stream_drain
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic                  err_underflow
);

    occ_t                 occ;
    logic                 pop;
    logic                 push;
    logic [2:0]           level;
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] beat_q, beat_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic                 err_q, err_d;

    always_comb begin
        m_valid = (occ != '0) && !flush;
        pop     = m_valid && m_ready;
        // Entries the buffer will hold once the in-flight word lands and this pop leaves.
        level   = 3'(occ) + 3'(inflight_q) - 3'(pop);
        fifo_rd_en = !fifo_empty && !flush && !rst && (level <= 3'd1);
        // A word arriving during flush belongs to the discarded stream.
        push       = inflight_q && !flush;
        inflight_d = fifo_rd_en;
    end

    always_comb begin
        beat_d  = beat_q + CNT_WIDTH'(pop);
        stall_d = stall_q;
        if (m_valid && !m_ready) begin
            stall_d = CNT_WIDTH'(sat_inc(64'(stall_q), CNT_WIDTH));
        end
        err_d = err_q || fifo_underflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
            stall_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (fifo_dout),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_data_o (m_data)
    );

    assign beat_count    = beat_q;
    assign stall_count   = stall_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural FIFO with 1-cycle read latency, directed scenarios
// and a randomized back-pressure run checked against a write-order scoreboard.
module tb_fifo_stream_drain;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_underflow = 1'b0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          flush = 1'b0;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] stall_count;
    logic          err_underflow;

    always #5 clk = ~clk;

    fifo_stream_drain #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_dout      (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .flush          (flush),
        .beat_count     (beat_count),
        .stall_count    (stall_count),
        .err_underflow  (err_underflow)
    );

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] fifo_q[$];
    logic          s_rd_en, s_valid, s_ready, s_err;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_beat, s_stall;
    bit            rd_when_empty = 0;

    // One clock cycle: starts just after a falling edge with inputs already driven.
    task automatic tick();
        logic [DW-1:0] nxt;
        nxt = '0;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        s_rd_en = fifo_rd_en;
        s_valid = m_valid;
        s_ready = m_ready;
        s_data  = m_data;
        s_beat  = beat_count;
        s_stall = stall_count;
        s_err   = err_underflow;
        if (s_rd_en && fifo_empty) rd_when_empty = 1;
        if (s_rd_en && fifo_q.size() != 0) nxt = fifo_q.pop_front();
        @(posedge clk);
        #1;
        fifo_dout = s_rd_en ? nxt : DW'($urandom);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
        fifo_q = {16'h0011, 16'h0022};
        tick();
        checks++;
        if (s_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en0: got %b want 0", s_rd_en); end
        tick();
        checks++;
        if (s_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en1: got %b want 0", s_rd_en); end
        checks++;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", s_valid); end
        checks++;
        if (s_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", s_data); end
        checks++;
        if (s_beat !== '0 || s_stall !== '0 || s_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_counts: got beat=%0d stall=%0d err=%b want 0 0 0", s_beat, s_stall, s_err);
        end
        fifo_q.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        int first_rd, first_v, last_v;
        logic [DW-1:0] got[$];
        logic [DW-1:0] want[3];
        logic [DW-1:0] act;
        want = '{16'h00A1, 16'h00A2, 16'h00A3};
        first_rd = -1; first_v = -1; last_v = -1;
        m_ready = 1'b1;
        fifo_q = {16'h00A1, 16'h00A2, 16'h00A3};
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_rd_en && first_rd < 0) first_rd = i;
            if (s_valid && s_ready) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                got.push_back(s_data);
            end
        end
        checks++;
        if (first_rd < 0 || first_v != first_rd + 2) begin
            errors++; $display("FAIL latency: first valid at %0d want %0d", first_v, first_rd + 2);
        end
        checks++;
        if (got.size() != 3 || last_v != first_v + 2) begin
            errors++; $display("FAIL latency_beats: got %0d beats ending at %0d want 3 ending at %0d",
                               got.size(), last_v, first_v + 2);
        end
        for (int k = 0; k < 3; k++) begin
            act = (k < got.size()) ? got[k] : 'x;
            checks++;
            if (act !== want[k]) begin errors++; $display("FAIL latency_data%0d: got %h want %h", k, act, want[k]); end
        end
        checks++;
        if (s_beat !== 8'd3) begin errors++; $display("FAIL latency_beat_count: got %0d want 3", s_beat); end
    endtask

    task automatic test_stall();
        int reads, stalls;
        bit stable;
        logic [CW-1:0] stall0, beat0;
        logic [DW-1:0] got[$];
        logic [DW-1:0] want[5];
        logic [DW-1:0] act;
        want = '{16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4, 16'h00B5};
        reads = 0; stalls = 0; stable = 1; stall0 = '0; beat0 = '0;
        m_ready = 1'b0;
        fifo_q = {16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4, 16'h00B5};
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) begin stall0 = s_stall; beat0 = s_beat; end
            if (s_rd_en) reads++;
            if (s_valid) begin
                stalls++;
                if (s_data !== 16'h00B1) stable = 0;
            end
        end
        checks++;
        if (reads != 2) begin errors++; $display("FAIL stall_reads: got %0d want 2", reads); end
        checks++;
        if (stalls != 6) begin errors++; $display("FAIL stall_valid_cycles: got %0d want 6", stalls); end
        checks++;
        if (!stable) begin errors++; $display("FAIL stall_data_stable: got changing data want %h held", want[0]); end
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (CW'(s_stall - stall0) !== 8'd6) begin
                    errors++; $display("FAIL stall_count: got %0d want 6", CW'(s_stall - stall0));
                end
            end
            if (s_valid && s_ready) got.push_back(s_data);
        end
        checks++;
        if (got.size() != 5) begin errors++; $display("FAIL stall_drain_count: got %0d want 5", got.size()); end
        for (int k = 0; k < 5; k++) begin
            act = (k < got.size()) ? got[k] : 'x;
            checks++;
            if (act !== want[k]) begin errors++; $display("FAIL stall_data%0d: got %h want %h", k, act, want[k]); end
        end
        checks++;
        if (CW'(s_beat - beat0) !== 8'd5) begin
            errors++; $display("FAIL stall_beats: got %0d want 5", CW'(s_beat - beat0));
        end
    endtask

    task automatic test_flush();
        logic [CW-1:0] beat0, stall_f;
        logic [DW-1:0] got[$];
        logic [DW-1:0] act;
        m_ready = 1'b0;
        fifo_q = {16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4};
        tick();
        beat0 = s_beat;
        tick();
        // One word buffered and one in flight when flush is pulsed.
        flush = 1'b1;
        tick();
        stall_f = s_stall;
        checks++;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_forced: got %b want 0", s_valid); end
        checks++;
        if (s_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en: got %b want 0", s_rd_en); end
        flush = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL flush_emptied: got valid %b want 0", s_valid); end
        checks++;
        if (s_rd_en !== 1'b1) begin errors++; $display("FAIL flush_resume: got rd_en %b want 1", s_rd_en); end
        checks++;
        if (s_stall !== stall_f) begin errors++; $display("FAIL flush_stall: got %0d want %0d", s_stall, stall_f); end
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_valid && s_ready) got.push_back(s_data);
        end
        checks++;
        if (got.size() != 2) begin errors++; $display("FAIL flush_drain_count: got %0d want 2", got.size()); end
        act = (got.size() > 0) ? got[0] : 'x;
        checks++;
        if (act !== 16'h00C3) begin errors++; $display("FAIL flush_data0: got %h want 00c3", act); end
        act = (got.size() > 1) ? got[1] : 'x;
        checks++;
        if (act !== 16'h00C4) begin errors++; $display("FAIL flush_data1: got %h want 00c4", act); end
        checks++;
        if (CW'(s_beat - beat0) !== 8'd2) begin
            errors++; $display("FAIL flush_beats: got %0d want 2", CW'(s_beat - beat0));
        end
    endtask

    task automatic test_underflow_rst();
        m_ready = 1'b1;
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        tick();
        checks++;
        if (s_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", s_err); end
        repeat (3) tick();
        checks++;
        if (s_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", s_err); end
        m_ready = 1'b0;
        fifo_q = {16'h00D1, 16'h00D2, 16'h00D3, 16'h00D4};
        repeat (4) tick();
        checks++;
        if (s_valid !== 1'b1 || s_data !== 16'h00D1) begin
            errors++; $display("FAIL rst_prefill: got valid=%b data=%h want 1 00d1", s_valid, s_data);
        end
        rst = 1'b1;
        fifo_q.delete();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_data !== '0) begin
            errors++; $display("FAIL rst_mid_valid: got valid=%b data=%h want 0 0000", s_valid, s_data);
        end
        checks++;
        if (s_err !== 1'b0 || s_beat !== '0 || s_stall !== '0) begin
            errors++;
            $display("FAIL rst_mid_counts: got err=%b beat=%0d stall=%0d want 0 0 0", s_err, s_beat, s_stall);
        end
        m_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_no_ghost: got valid %b want 0", s_valid); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] w, want, prev_data;
        int pushed, beats, stalls, want_stall;
        bit prev_stall;
        pushed = 0; beats = 0; stalls = 0; prev_stall = 0; prev_data = '0;
        for (int c = 0; c < 20000 && beats < 1000; c++) begin
            if (pushed < 1000 && fifo_q.size() < 6 && $urandom_range(0, 3) != 0) begin
                w = DW'($urandom);
                fifo_q.push_back(w);
                exp_q.push_back(w);
                pushed++;
            end
            m_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (prev_stall) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== prev_data) begin
                    errors++;
                    $display("FAIL rand_hold: got valid=%b data=%h want 1 %h", s_valid, s_data, prev_data);
                end
            end
            if (s_valid && s_ready) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (s_data !== want) begin
                    errors++; $display("FAIL rand_beat%0d: got %h want %h", beats, s_data, want);
                end
                beats++;
            end
            if (s_valid && !s_ready) stalls++;
            prev_stall = s_valid && !s_ready;
            prev_data  = s_data;
        end
        checks++;
        if (beats != 1000) begin errors++; $display("FAIL rand_timeout: got %0d beats want 1000", beats); end
        m_ready = 1'b1;
        tick();
        checks++;
        if (s_beat !== CW'(beats)) begin
            errors++; $display("FAIL rand_beat_count: got %0d want %0d", s_beat, CW'(beats));
        end
        want_stall = (stalls > 255) ? 255 : stalls;
        checks++;
        if (s_stall !== CW'(want_stall)) begin
            errors++; $display("FAIL rand_stall_count: got %0d want %0d", s_stall, want_stall);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_underflow_rst();
        test_random();
        checks++;
        if (rd_when_empty) begin errors++; $display("FAIL rd_en_while_empty: got 1 want 0"); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
